// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit core: opcodes, datapath width, MUL/DIV FSM encoding.
package cpu_pkg;

  localparam logic [3:0] OP_MUL = 4'b0011;
  localparam logic [3:0] OP_DIV = 4'b0110;

  localparam int WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/muldiv_sequencer.sv
// Multi-cycle unsigned multiply (shift-add) / divide (restoring) unit.
// Runs one iteration per clock and stalls the core until the result is ready.
module muldiv_sequencer
  import cpu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_div,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic             op_div_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_hi_q;   // product high half / partial remainder
  logic [WIDTH-1:0] acc_lo_q;   // multiplier bits shifting out / quotient bits shifting in
  logic [WIDTH-1:0] result_lo_q;
  logic [WIDTH-1:0] result_hi_q;
  logic             dbz_q;
  logic             done_q;

  logic [WIDTH-1:0] acc_hi_d;
  logic [WIDTH-1:0] acc_lo_d;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic             div_ge;

  // One iteration of the shared accumulator: shift-add for MUL, restoring subtract for DIV.
  always_comb begin
    mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, b_q} : '0);
    // Shifted remainder needs one extra bit: it can reach 2*divisor-1.
    rem_sh   = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_ge   = (rem_sh >= {1'b0, b_q});
    acc_hi_d = mul_sum[WIDTH:1];
    acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
    if (op_div_q) begin
      // When the trial succeeds the difference is below the divisor, so WIDTH bits suffice.
      acc_hi_d = div_ge ? (rem_sh[WIDTH-1:0] - b_q) : rem_sh[WIDTH-1:0];
      acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ge};
    end
  end

  // Controller FSM with datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_div_q    <= 1'b0;
      b_q         <= '0;
      acc_hi_q    <= '0;
      acc_lo_q    <= '0;
      result_lo_q <= '0;
      result_hi_q <= '0;
      dbz_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            op_div_q <= op_div;
            b_q      <= operand_b;
            acc_hi_q <= '0;
            acc_lo_q <= operand_a;
            cnt_q    <= '0;
            dbz_q    <= 1'b0;
            if (op_div && (operand_b == '0)) begin
              // Divide by zero skips the iterations entirely.
              result_lo_q <= '1;
              result_hi_q <= operand_a;
              dbz_q       <= 1'b1;
              done_q      <= 1'b1;
              state_q     <= DONE;
            end else begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          acc_hi_q <= acc_hi_d;
          acc_lo_q <= acc_lo_d;
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            result_hi_q <= acc_hi_d;
            result_lo_q <= acc_lo_d;
            done_q      <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          // The core still presents the finished instruction here, so start is ignored.
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Stall must freeze the PC in the decode cycle itself, hence the direct start term.
  assign stall       = rst_n & (((state_q == IDLE) & start) | (state_q == RUN));
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign result_lo   = result_lo_q;
  assign result_hi   = result_hi_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: transaction model plus directed vectors.
module tb_muldiv_sequencer;

  localparam int W = 16;
  localparam int LAT_RUN = W + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          op_div = 1'b0;
  logic [W-1:0]  operand_a = '0;
  logic [W-1:0]  operand_b = '0;
  logic          stall;
  logic          busy;
  logic          done;
  logic [W-1:0]  result_lo;
  logic [W-1:0]  result_hi;
  logic          div_by_zero;

  int n_tests = 0;
  int n_fail  = 0;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .op_div     (op_div),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .stall      (stall),
    .busy       (busy),
    .done       (done),
    .result_lo  (result_lo),
    .result_hi  (result_hi),
    .div_by_zero(div_by_zero)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // m_k = cycles elapsed since the instruction was accepted (0 = nothing in flight).
  int           m_k   = 0;
  int           m_lat = 0;
  logic [W-1:0] m_lo  = '0;
  logic [W-1:0] m_hi  = '0;
  logic         m_dbz = 1'b0;
  logic [W-1:0] p_lo;
  logic [W-1:0] p_hi;
  logic [2*W-1:0] prod;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_k = 0; m_lat = 0; m_lo = '0; m_hi = '0; m_dbz = 1'b0;
    end else if (m_k == 0) begin
      if (start) begin
        m_dbz = 1'b0;
        if (op_div && operand_b == '0) begin
          p_lo = '1; p_hi = operand_a; m_dbz = 1'b1; m_lat = 1;
        end else if (op_div) begin
          p_lo = operand_a / operand_b; p_hi = operand_a % operand_b; m_lat = LAT_RUN;
        end else begin
          prod = {{W{1'b0}}, operand_a} * {{W{1'b0}}, operand_b};
          p_lo = prod[W-1:0]; p_hi = prod[2*W-1:W]; m_lat = LAT_RUN;
        end
        m_k = 1;
        if (m_k == m_lat) begin m_lo = p_lo; m_hi = p_hi; end
      end
    end else if (m_k == m_lat) begin
      m_k = 0;
    end else begin
      m_k++;
      if (m_k == m_lat) begin m_lo = p_lo; m_hi = p_hi; end
    end
  end

  // Compare DUT against the model on every falling edge.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      chk("rst_busy", busy, 0);
      chk("rst_stall", stall, 0);
      chk("rst_done", done, 0);
      chk("rst_lo", result_lo, 0);
      chk("rst_hi", result_hi, 0);
      chk("rst_dbz", div_by_zero, 0);
    end else begin
      chk("cyc_busy", busy, 32'(m_k != 0));
      chk("cyc_done", done, 32'(m_k != 0 && m_k == m_lat));
      chk("cyc_stall", stall, 32'((m_k != 0 && m_k < m_lat) || (m_k == 0 && start)));
      chk("cyc_lo", result_lo, m_lo);
      chk("cyc_hi", result_hi, m_hi);
      chk("cyc_dbz", div_by_zero, m_dbz);
    end
  end

  // Issue one instruction at posedge+1 with start held; returns at posedge+1 of the
  // IDLE cycle after DONE with start still high.
  task automatic run_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic dv, input logic [W-1:0] elo, input logic [W-1:0] ehi,
                        input logic edbz, input int elat);
    int cyc;
    int nstall;
    bit seen;
    operand_a = a; operand_b = b; op_div = dv; start = 1'b1;
    cyc = 0; nstall = 0; seen = 1'b0;
    while (cyc <= 40 && !seen) begin
      @(negedge clk);
      if (stall) nstall++;
      if (done) seen = 1'b1;
      else cyc++;
    end
    chk({nm, "_done_seen"}, 32'(seen), 1);
    if (seen) begin
      chk({nm, "_latency"}, cyc, elat);
      chk({nm, "_stall_cycles"}, nstall, elat);
      chk({nm, "_lo"}, result_lo, elo);
      chk({nm, "_hi"}, result_hi, ehi);
      chk({nm, "_dbz"}, div_by_zero, edbz);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_lo", result_lo, 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("mul_7x9",     16'd7,    16'd9,    1'b0, 16'h003F, 16'h0000, 1'b0, 17);
    idle(2);
    run_op("mul_max",     16'hFFFF, 16'hFFFF, 1'b0, 16'h0001, 16'hFFFE, 1'b0, 17);
    idle(1);
    run_op("mul_1234",    16'h1234, 16'h5678, 1'b0, 16'h0060, 16'h0626, 1'b0, 17);
    idle(1);
    run_op("div_100_7",   16'd100,  16'd7,    1'b1, 16'h000E, 16'h0002, 1'b0, 17);
    idle(1);
    run_op("div_5_9",     16'h0005, 16'h0009, 1'b1, 16'h0000, 16'h0005, 1'b0, 17);
    idle(1);
    run_op("div_8000_3",  16'h8000, 16'h0003, 1'b1, 16'h2AAA, 16'h0002, 1'b0, 17);
    idle(1);
    run_op("div_ffff_1",  16'hFFFF, 16'h0001, 1'b1, 16'hFFFF, 16'h0000, 1'b0, 17);
    idle(1);
    run_op("div_ffff_ff", 16'hFFFF, 16'hFFFF, 1'b1, 16'h0001, 16'h0000, 1'b0, 17);
    idle(1);
    run_op("div_by_zero", 16'h1234, 16'h0000, 1'b1, 16'hFFFF, 16'h1234, 1'b1, 1);
    idle(1);
    // MUL after divide-by-zero clears the flag; then back-to-back with start never dropped.
    run_op("mul_2x3",     16'd2,    16'd3,    1'b0, 16'h0006, 16'h0000, 1'b0, 17);
    run_op("mul_3x4_b2b", 16'd3,    16'd4,    1'b0, 16'h000C, 16'h0000, 1'b0, 17);
    idle(1);

    // Asynchronous reset in the middle of a multiply.
    operand_a = 16'h00AB; operand_b = 16'h0101; op_div = 1'b0; start = 1'b1;
    repeat (9) @(negedge clk);
    chk("midrun_busy", busy, 1);
    chk("midrun_stall", stall, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_busy", busy, 0);
    chk("async_stall", stall, 0);
    chk("async_done", done, 0);
    chk("async_lo", result_lo, 0);
    chk("async_hi", result_hi, 0);
    chk("async_dbz", div_by_zero, 0);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("mul_5x6_after_rst", 16'd5, 16'd6, 1'b0, 16'h001E, 16'h0000, 1'b0, 17);
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle controller and iterative datapath for the MUL (opcode 4'b0011) and DIV (opcode 4'b0110) instructions of the 16-bit core.
- Accepts operands from the register file, runs WIDTH shift-add or restoring-subtract iterations, and stalls the PC and register write-back until the result is ready.
- Sits beside the ALU. The control-unit decode of MUL/DIV drives start; this block's outputs feed the write-back mux.

Parameters:
- WIDTH, 16, operand/result width. The iteration counter is $clog2(WIDTH)+1 bits wide.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  decoded MUL/DIV instruction present; held by the core while the instruction is stalled
- op_div  in  1  0 = unsigned multiply, 1 = unsigned divide
- operand_a  in  WIDTH  multiplicand / dividend
- operand_b  in  WIDTH  multiplier / divisor
- stall  out  1  freeze PC and suppress other write-back
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse: results valid, write-back enable
- result_lo  out  WIDTH  product low half / quotient
- result_hi  out  WIDTH  product high half / remainder
- div_by_zero  out  1  sticky flag for the last DIV; valid with done

Behaviour:
- Reset (async, rst_n=0): state=IDLE, counter=0; result_lo, result_hi, div_by_zero, done = 0; stall=0. Release of reset is synchronous to clk.
- FSM states: IDLE, RUN, DONE.
- IDLE
  - stall = start (combinational). This freezes the PC in the same cycle the instruction is decoded.
  - On an edge with start=1, latch the operands, clear the counter, capture op_div, then go to RUN.
  - Exception: op_div=1 with operand_b=0 goes straight to DONE with result_lo=all-ones, result_hi=operand_a, div_by_zero=1.
- RUN
  - stall=1. One iteration per edge; the counter increments.
  - After iteration WIDTH (counter == WIDTH-1 at the edge), go to DONE.
- DONE
  - done=1, stall=0. The PC advances and write-back occurs at this edge.
  - Next state is IDLE unconditionally. start is ignored in DONE because the core still holds the completed instruction.
- Latency:
  - start accepted at edge 0; done is high in cycle WIDTH+1 (cycle 17 for WIDTH=16).
  - Divide-by-zero: done in cycle 1.
  - Back-to-back MUL/DIV: the next start is accepted in the IDLE cycle immediately after DONE.
- Multiply (unsigned, shift-add)
  - acc_hi=0, acc_lo=operand_a initially.
  - Each iteration: if acc_lo[0], sum = {1'b0,acc_hi} + operand_b (WIDTH+1 bits); then {carry,acc_hi,acc_lo} >>= 1.
  - Final: {result_hi,result_lo} = full 2*WIDTH product. No overflow is possible.
- Divide (unsigned, restoring)
  - rem=0, quo=operand_a initially.
  - Each iteration: {rem,quo} <<= 1; trial = rem - operand_b (WIDTH+1 bits). If trial is non-negative, rem=trial and quo[0]=1.
  - Final: result_lo=quo, result_hi=rem.
- Result registers are updated only on the DONE transition and hold until the next accepted start. Intermediate values are not visible on result_*.
- div_by_zero: cleared on every accepted start, set only in the b=0 case.
- start while busy in RUN: ignored; the operand inputs are don't-care after acceptance.
- Reset mid-operation: immediate return to IDLE with all outputs zero. The core re-fetches after reset, so no partial result survives.

Decomposition:
- Shared package cpu_pkg:
  - opcode constants OP_MUL=4'b0011 and OP_DIV=4'b0110
  - WIDTH default (16)
  - FSM state encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10)
- Single module; accumulator/shift datapath is inline (about 150–250 lines). No sub-module.

Test Plan:
- MUL 7 x 9, start held until done -> stall high cycles 0–16, done only in cycle 17; result_lo=0x003F, result_hi=0x0000, div_by_zero=0.
- MUL 0xFFFF x 0xFFFF -> result_hi=0xFFFE, result_lo=0x0001 at done; single done pulse.
- DIV 100 / 7 -> result_lo=0x000E, result_hi=0x0002 in cycle 17. DIV 0x0005 / 0x0009 -> quotient 0, remainder 5.
- DIV 0x1234 / 0 -> done in cycle 1; result_lo=0xFFFF, result_hi=0x1234, div_by_zero=1. A following MUL clears div_by_zero.
- Assert rst_n=0 asynchronously mid-cycle at RUN iteration 8 -> busy, stall, done, and result_* drop to 0 without a clock edge; a new start after release completes normally.
- Start held high through DONE, then MUL 3 x 4 in the next cycle -> exactly one done per instruction, second start accepted in the IDLE cycle after DONE; result_lo=0x000C 17 cycles later.
